// File: rtl/data_formatter_pkg.sv
// Shared definitions for the data slicer: the controller state encoding and
// helpers that size the width-select and chunk-count fields from the input
// word width.
package data_formatter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // log2 of the widest slice, i.e. the largest meaningful width select
   function automatic int unsigned max_width_sel(input int unsigned low_dim_width);
      return $clog2(low_dim_width);
   endfunction

   // Bits needed to carry a width select in 0..log2(low_dim_width)
   function automatic int unsigned width_sel_bits(input int unsigned low_dim_width);
      return $clog2($clog2(low_dim_width) + 1);
   endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Small synchronous FIFO with a synchronous flush.
// Ports: clk_i clock; clr_i flush (pointers and count to zero);
//        push_i/data_i/full_o write side; pop_i/data_o/empty_o read side.
// With FallThrough=0 a word pushed in cycle N is visible at the output in N+1.
// A push while full is dropped; push and pop in the same cycle both apply.
module fifo_buffer #(
   parameter bit          FallThrough = 1'b0,
   parameter int unsigned DataWidth   = 8,
   parameter int unsigned FifoDepth   = 4,
   localparam int unsigned PtrW       = (FifoDepth > 1) ? $clog2(FifoDepth) : 1,
   localparam int unsigned CntW       = $clog2(FifoDepth + 1)
) (
   input  logic                 clk_i,
   input  logic                 clr_i,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 full_o,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 empty_o
);

   logic [DataWidth-1:0] r_mem [FifoDepth];
   logic [PtrW-1:0]      r_wr_ptr;
   logic [PtrW-1:0]      r_rd_ptr;
   logic [CntW-1:0]      r_count;
   logic                 w_mem_empty;
   logic                 w_full;
   logic                 w_bypass;
   logic                 w_do_push;
   logic                 w_do_pop;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign w_mem_empty = (r_count == '0);
   assign w_full      = (r_count == CntW'(FifoDepth));
   // in fall-through mode a word pushed and popped while empty never lands in memory
   assign w_bypass    = FallThrough && w_mem_empty && push_i && pop_i;
   assign w_do_push   = push_i && !w_full && !w_bypass;
   assign w_do_pop    = pop_i && !w_mem_empty;

   always_ff @(posedge clk_i) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign full_o  = w_full;
   assign empty_o = FallThrough ? (w_mem_empty && !push_i) : w_mem_empty;
   assign data_o  = (FallThrough && w_mem_empty) ? data_i : r_mem[r_rd_ptr];

endmodule

// File: rtl/param_data_slicer.sv
// Cuts input words into 2^sel-bit slices (LSB chunk first), adds an address
// offset to each slice and queues the results as item-memory addresses.
//
// state | meaning
// IDLE  | waiting for start_i; configuration is captured on start
// RUN   | pushing one slice per cycle while input is valid and queue has room
// DRAIN | all slices pushed; done_o pulses when the queue runs empty
//
// Ports: clk_i/rst_i clock and sync reset; start_i/clr_i stream control;
//        sel_width_i, csr_elem_size_i, csr_addr_offset_i stream config;
//        lowdim_data_i/_valid_i/_ready_o input words;
//        addr_o/addr_valid_o/addr_ready_i address stream; busy_o, done_o status.
module param_data_slicer
   import data_formatter_pkg::*;
#(
   parameter int unsigned  LowDimWidth  = 64,
   parameter int unsigned  NumTotIm     = 1024,
   parameter int unsigned  FifoDepth    = 4,
   parameter int unsigned  CsrDataWidth = 32,
   localparam int unsigned ImAddrWidth  = $clog2(NumTotIm),
   localparam int unsigned WidthSelW    = width_sel_bits(LowDimWidth)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    clr_i,
   input  logic [WidthSelW-1:0]    sel_width_i,
   input  logic [CsrDataWidth-1:0] csr_elem_size_i,
   input  logic [ImAddrWidth-1:0]  csr_addr_offset_i,
   input  logic [LowDimWidth-1:0]  lowdim_data_i,
   input  logic                    lowdim_data_valid_i,
   output logic                    lowdim_data_ready_o,
   output logic [ImAddrWidth-1:0]  addr_o,
   output logic                    addr_valid_o,
   input  logic                    addr_ready_i,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int unsigned          ChunkW = max_width_sel(LowDimWidth) + 1;
   localparam logic [WidthSelW-1:0] SelMax = WidthSelW'(max_width_sel(LowDimWidth));

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [WidthSelW-1:0]    r_sel;
   logic [CsrDataWidth-1:0] r_elem_size;
   logic [CsrDataWidth-1:0] r_elem_cnt;
   logic [ImAddrWidth-1:0]  r_offset;
   logic [ChunkW-1:0]       r_chunk_cnt;

   logic                    w_abort;
   logic                    w_start;
   logic                    w_done;
   logic [ChunkW-1:0]       w_last_chunk_idx;
   logic [ChunkW-1:0]       w_width;
   logic [ChunkW-1:0]       w_bit_off;
   logic [LowDimWidth-1:0]  w_mask;
   logic [ImAddrWidth-1:0]  w_slice_addr;
   logic                    w_last_chunk;
   logic                    w_last_elem;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_word_done;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic [ImAddrWidth-1:0]  w_fifo_data;

   assign w_abort = rst_i || clr_i;
   assign w_start = (r_state == IDLE) && start_i && !w_abort;

   assign w_last_chunk_idx = (ChunkW'(1) << (SelMax - r_sel)) - ChunkW'(1);
   assign w_width          = ChunkW'(1) << r_sel;
   assign w_bit_off        = r_chunk_cnt << r_sel;
   // a full-word slice shifts every bit out, leaving an all-ones mask
   assign w_mask           = ~({LowDimWidth{1'b1}} << w_width);
   // zero-extend or truncate the slice to an address, then wrap-add the offset
   assign w_slice_addr     = ImAddrWidth'((lowdim_data_i >> w_bit_off) & w_mask) + r_offset;

   assign w_last_chunk = (r_chunk_cnt == w_last_chunk_idx);
   assign w_last_elem  = (r_elem_cnt == r_elem_size - CsrDataWidth'(1));
   assign w_push       = (r_state == RUN) && lowdim_data_valid_i && !w_fifo_full && !w_abort;
   assign w_pop        = !w_fifo_empty && addr_ready_i;
   assign w_word_done  = w_push && (w_last_chunk || w_last_elem);

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         IDLE:    if (start_i) w_state_nxt = (csr_elem_size_i == '0) ? DRAIN : RUN;
         RUN:     if (w_push && w_last_elem) w_state_nxt = DRAIN;
         DRAIN: begin
            if (w_fifo_empty) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_abort) begin
         w_state_nxt = IDLE;
         w_done      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (w_abort) begin
         r_sel       <= '0;
         r_elem_size <= '0;
         r_offset    <= '0;
         r_elem_cnt  <= '0;
         r_chunk_cnt <= '0;
      end else if (w_start) begin
         r_sel       <= (sel_width_i > SelMax) ? SelMax : sel_width_i;
         r_elem_size <= csr_elem_size_i;
         r_offset    <= csr_addr_offset_i;
         r_elem_cnt  <= '0;
         r_chunk_cnt <= '0;
      end else if (w_done) begin
         r_elem_cnt  <= '0;
         r_chunk_cnt <= '0;
      end else if (w_push) begin
         r_elem_cnt  <= r_elem_cnt + CsrDataWidth'(1);
         r_chunk_cnt <= w_word_done ? '0 : r_chunk_cnt + ChunkW'(1);
      end
   end

   fifo_buffer #(
      .FallThrough (1'b0),
      .DataWidth   (ImAddrWidth),
      .FifoDepth   (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .clr_i   (w_abort),
      .push_i  (w_push),
      .data_i  (w_slice_addr),
      .full_o  (w_fifo_full),
      .pop_i   (w_pop),
      .data_o  (w_fifo_data),
      .empty_o (w_fifo_empty)
   );

   assign lowdim_data_ready_o = w_word_done;
   // storage is not reset, so hide stale contents while nothing is queued
   assign addr_o              = w_fifo_empty ? '0 : w_fifo_data;
   assign addr_valid_o        = !w_fifo_empty;
   assign busy_o              = (r_state != IDLE);
   assign done_o              = w_done;

endmodule

// File: tb/tb_param_data_slicer.sv
// Directed bench for param_data_slicer with default parameters.
module tb_param_data_slicer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        clr_i;
   logic [2:0]  sel_width_i;
   logic [31:0] csr_elem_size_i;
   logic [9:0]  csr_addr_offset_i;
   logic [63:0] lowdim_data_i;
   logic        lowdim_data_valid_i;
   logic        lowdim_data_ready_o;
   logic [9:0]  addr_o;
   logic        addr_valid_o;
   logic        addr_ready_i;
   logic        busy_o;
   logic        done_o;

   param_data_slicer dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .start_i             (start_i),
      .clr_i               (clr_i),
      .sel_width_i         (sel_width_i),
      .csr_elem_size_i     (csr_elem_size_i),
      .csr_addr_offset_i   (csr_addr_offset_i),
      .lowdim_data_i       (lowdim_data_i),
      .lowdim_data_valid_i (lowdim_data_valid_i),
      .lowdim_data_ready_o (lowdim_data_ready_o),
      .addr_o              (addr_o),
      .addr_valid_o        (addr_valid_o),
      .addr_ready_i        (addr_ready_i),
      .busy_o              (busy_o),
      .done_o              (done_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic [9:0] pop_q [$];
   int n_ready = 0, ready_cyc = 0, n_done = 0, done_cyc = 0, last_pop_cyc = 0, n_busy = 0;

   always @(negedge clk_i) begin
      if (addr_valid_o && addr_ready_i) begin
         pop_q.push_back(addr_o);
         last_pop_cyc = cyc;
      end
      if (lowdim_data_ready_o) begin
         n_ready++;
         ready_cyc = cyc;
      end
      if (done_o) begin
         n_done++;
         done_cyc = cyc;
      end
      if (busy_o) n_busy++;
   end

   int n_checks = 0;
   int n_errors = 0;
   int pop_base, ready_base, done_base, busy_base, start_cyc, word_idx;
   logic [63:0] words [3];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic capture_base();
      pop_base   = pop_q.size();
      ready_base = n_ready;
      done_base  = n_done;
      busy_base  = n_busy;
   endtask

   // config is scrambled after the start cycle; the DUT must hold its own copy
   task automatic start_stream(input logic [2:0] sel, input logic [31:0] elem, input logic [9:0] off);
      capture_base();
      sel_width_i       = sel;
      csr_elem_size_i   = elem;
      csr_addr_offset_i = off;
      start_i           = 1'b1;
      start_cyc         = cyc;
      tick(1);
      start_i           = 1'b0;
      sel_width_i       = sel ^ 3'b001;
      csr_elem_size_i   = 32'h0000_DEAD;
      csr_addr_offset_i = off ^ 10'h155;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && n_done == done_base; k++) begin
         @(negedge clk_i);
         if (lowdim_data_ready_o) begin
            @(posedge clk_i);
            #1;
            if (word_idx < 2) word_idx++;
            lowdim_data_i = words[word_idx];
         end
      end
      tick(2);
   endtask

   task automatic run_stream(input logic [2:0] sel, input logic [31:0] elem, input logic [9:0] off,
                             input int budget);
      word_idx            = 0;
      lowdim_data_i       = words[0];
      lowdim_data_valid_i = 1'b1;
      start_stream(sel, elem, off);
      wait_done(budget);
      lowdim_data_valid_i = 1'b0;
   endtask

   task automatic check_seq_1_to_8(input string tag);
      check_eq({tag, "_count"}, pop_q.size() - pop_base, 8);
      for (int i = 0; i < 8; i++)
         check_eq({tag, "_addr"}, pop_q[pop_base + i], i + 1);
   endtask

   initial begin
      logic [63:0] w0, w1;
      int rel_cyc;
      rst_i = 1'b1; start_i = 1'b0; clr_i = 1'b0; sel_width_i = '0;
      csr_elem_size_i = '0; csr_addr_offset_i = '0; lowdim_data_i = '0;
      lowdim_data_valid_i = 1'b0; addr_ready_i = 1'b0;
      words[0] = '0; words[1] = '0; words[2] = '0;
      tick(3);
      @(negedge clk_i);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_valid", addr_valid_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_ready", lowdim_data_ready_o, 0);
      check_eq("rst_addr", addr_o, 0);
      tick(1);
      rst_i = 1'b0;
      tick(2);

      // bytes of one word, offset 0
      addr_ready_i = 1'b1;
      words[0] = 64'h0807_0605_0403_0201;
      run_stream(3'd3, 32'd8, 10'd0, 60);
      check_seq_1_to_8("bytes");
      check_eq("bytes_ready_n", n_ready - ready_base, 1);
      check_eq("bytes_ready_at", ready_cyc, start_cyc + 8);
      check_eq("bytes_ready_vs_pop", ready_cyc, last_pop_cyc - 1);
      check_eq("bytes_done_n", n_done - done_base, 1);
      check_eq("bytes_done_at", done_cyc, last_pop_cyc + 1);

      // single bits across two words, offset 16
      words[0] = 64'hA5A5_0F0F_1234_8001;
      words[1] = 64'h0000_0000_0000_002D;
      words[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      w0 = words[0];
      w1 = words[1];
      run_stream(3'd0, 32'd70, 10'd16, 200);
      check_eq("bits_count", pop_q.size() - pop_base, 70);
      for (int i = 0; i < 70; i++)
         check_eq("bits_addr", pop_q[pop_base + i], (i < 64 ? w0[i] : w1[i - 64]) + 16);
      check_eq("bits_words_used", n_ready - ready_base, 2);
      check_eq("bits_done_n", n_done - done_base, 1);

      // nibble with offset wrapping past the top of the item memory
      words[0] = 64'h0000_0000_0000_000F;
      run_stream(3'd2, 32'd1, 10'd1020, 30);
      check_eq("wrap_count", pop_q.size() - pop_base, 1);
      check_eq("wrap_addr", pop_q[pop_base], 11);
      check_eq("wrap_ready_n", n_ready - ready_base, 1);

      // out-of-range select clamps to the full word, truncated to 10 bits
      words[0] = 64'h0000_0000_0000_0123;
      words[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      run_stream(3'd7, 32'd2, 10'd5, 30);
      check_eq("clamp_count", pop_q.size() - pop_base, 2);
      check_eq("clamp_addr0", pop_q[pop_base], 296);
      check_eq("clamp_addr1", pop_q[pop_base + 1], 4);
      check_eq("clamp_ready_n", n_ready - ready_base, 2);

      // consumer stalls: queue fills to four, then drains in order
      addr_ready_i = 1'b0;
      words[0] = 64'h0807_0605_0403_0201;
      word_idx = 0;
      lowdim_data_i = words[0];
      lowdim_data_valid_i = 1'b1;
      start_stream(3'd3, 32'd8, 10'd0);
      tick(10);
      @(negedge clk_i);
      check_eq("stall_valid", addr_valid_o, 1);
      check_eq("stall_busy", busy_o, 1);
      check_eq("stall_ready_n", n_ready - ready_base, 0);
      tick(1);
      addr_ready_i = 1'b1;
      rel_cyc = cyc;
      wait_done(40);
      lowdim_data_valid_i = 1'b0;
      check_seq_1_to_8("stall");
      check_eq("stall_ready_at", ready_cyc, rel_cyc + 4);
      check_eq("stall_done_at", done_cyc, rel_cyc + 8);
      check_eq("stall_done_n", n_done - done_base, 1);

      // clear in the same cycle as start wins
      capture_base();
      lowdim_data_valid_i = 1'b1;
      sel_width_i = 3'd3; csr_elem_size_i = 32'd8; csr_addr_offset_i = 10'd0;
      start_i = 1'b1; clr_i = 1'b1;
      tick(1);
      start_i = 1'b0; clr_i = 1'b0;
      @(negedge clk_i);
      check_eq("clrstart_busy", busy_o, 0);
      check_eq("clrstart_valid", addr_valid_o, 0);
      tick(5);
      check_eq("clrstart_pops", pop_q.size() - pop_base, 0);
      check_eq("clrstart_done", n_done - done_base, 0);

      // clear mid-stream flushes the queue and suppresses done
      addr_ready_i = 1'b0;
      start_stream(3'd3, 32'd8, 10'd0);
      tick(2);
      clr_i = 1'b1;
      tick(1);
      clr_i = 1'b0;
      @(negedge clk_i);
      check_eq("clrrun_busy", busy_o, 0);
      check_eq("clrrun_valid", addr_valid_o, 0);
      tick(1);
      addr_ready_i = 1'b1;
      tick(6);
      check_eq("clrrun_pops", pop_q.size() - pop_base, 0);
      check_eq("clrrun_done", n_done - done_base, 0);
      check_eq("clrrun_ready", n_ready - ready_base, 0);
      run_stream(3'd3, 32'd8, 10'd0, 60);
      check_seq_1_to_8("restart");

      // empty stream
      start_stream(3'd3, 32'd0, 10'd0);
      tick(4);
      check_eq("empty_busy_cycles", n_busy - busy_base, 1);
      check_eq("empty_done_n", n_done - done_base, 1);
      check_eq("empty_done_at", done_cyc, start_cyc + 1);
      check_eq("empty_pops", pop_q.size() - pop_base, 0);

      // reset mid-stream discards queued slices
      addr_ready_i = 1'b0;
      lowdim_data_valid_i = 1'b1;
      start_stream(3'd3, 32'd8, 10'd0);
      tick(3);
      rst_i = 1'b1;
      tick(1);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_eq("rstrun_valid", addr_valid_o, 0);
      check_eq("rstrun_busy", busy_o, 0);
      tick(1);
      addr_ready_i = 1'b1;
      tick(6);
      check_eq("rstrun_pops", pop_q.size() - pop_base, 0);
      check_eq("rstrun_done", n_done - done_base, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/param_data_slicer.md
PARAM_DATA_SLICER -- requirements
Module: param_data_slicer

Interface
REQ-001 Parameters SHALL be: LowDimWidth, default 64, input word width (power of two, at least 8).
REQ-002 NumTotIm, default 1024, item-memory depth; ImAddrWidth = $clog2(NumTotIm), derived and not overridden.
REQ-003 FifoDepth, default 4, output FIFO entries; CsrDataWidth, default 32; WidthSelW = $clog2($clog2(LowDimWidth)+1), derived.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Ports (name / direction / width / meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, pulse; begins a stream.
- clr_i, in, 1, synchronous abort and flush.
- sel_width_i, in, WidthSelW, slice width = 2^sel_width_i bits.
- csr_elem_size_i, in, CsrDataWidth, number of slices in the stream.
- csr_addr_offset_i, in, ImAddrWidth, offset added to every slice.
- lowdim_data_i, in, LowDimWidth, input word.
- lowdim_data_valid_i, in, 1, input valid.
- lowdim_data_ready_o, out, 1, input word consumed.
- addr_o, out, ImAddrWidth, item-memory address.
- addr_valid_o, out, 1, address valid.
- addr_ready_i, in, 1, address accepted.
- busy_o, out, 1, FSM not in IDLE.
- done_o, out, 1, one-cycle pulse at stream end.

Function
REQ-006 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-007 Transitions:
- IDLE->RUN on start_i.
- RUN->DRAIN on the push of the last element.
- DRAIN->IDLE when the FIFO is empty, with done_o asserted in that same cycle.
REQ-008 start_i in IDLE with csr_elem_size_i==0 SHALL go straight to DRAIN, so done_o pulses one cycle later with no pushes.
REQ-009 The slice width w SHALL be 2^min(sel_width_i, log2(LowDimWidth)); out-of-range selects clamp to the full word.
REQ-010 sel_width_i, csr_elem_size_i and csr_addr_offset_i SHALL be sampled at start_i and held internally for the whole stream.
REQ-011 Chunks per word SHALL be LowDimWidth/w; chunk k is lowdim_data_i[w*k +: w], so chunk 0 is the LSBs.
REQ-012 Address formation:
- Slice zero-extended, or truncated to its low ImAddrWidth bits.
- Plus the offset, modulo 2^ImAddrWidth (wrap, no saturation).
REQ-013 Push SHALL occur exactly when state==RUN, lowdim_data_valid_i is high and the FIFO is not full; at most one slice per cycle.
REQ-014 On each push, the chunk and element counters SHALL increment.
REQ-015 The chunk counter SHALL wrap to 0 after the last chunk of a word or after the last element.
REQ-016 lowdim_data_ready_o SHALL equal push AND (last chunk OR last element), i.e. the word is consumed in the same cycle as its final push; a partially used last word is discarded.
REQ-017 Pop SHALL equal addr_valid_o AND addr_ready_i.
REQ-018 addr_valid_o SHALL be !fifo_empty; FIFO latency is one cycle (push at cycle N gives valid at N+1).
REQ-019 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full (pop frees space only next cycle; no push into a full FIFO).
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 clr_i SHALL take priority over start_i and all other inputs. The following cycle:
- State is IDLE and counters are 0.
- FIFO is flushed.
- done_o does not pulse.
REQ-022 The element counter SHALL be CsrDataWidth bits wide; the chunk counter SHALL be $clog2(LowDimWidth)+1 bits wide.

Reset
REQ-023 With rst_i high at a clock edge, the block SHALL on the next cycle have:
- State IDLE, counters 0, FIFO empty.
- Outputs 0: lowdim_data_ready_o, addr_valid_o, busy_o, done_o.
- addr_o 0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight slices, with no done_o pulse.

Structure
REQ-025 A shared package data_formatter_pkg SHALL hold the FSM state enum and width-select helper constants.
REQ-026 The output queue SHALL instantiate the existing fifo_buffer as the single sub-module: FallThrough=0, DataWidth=ImAddrWidth, FifoDepth=FifoDepth, clr_i driven by clr_i OR rst_i.

Verification
REQ-027 Scenario: sel_width=3, elem=8, offset=0, word=0x0807060504030201, addr_ready_i=1 -> addrs 1..8 in order; ready_o high only on the 8th push; done_o one cycle after the last pop.
REQ-028 Scenario: sel_width=0, elem=70, offset=16, two words -> 64 bits from word0 then 6 from word1, each addr = bit+16; word1 consumed on element 70.
REQ-029 Scenario: sel_width=2, offset=1020 (NumTotIm=1024), nibble 0xF -> addr 11 (wrap).
REQ-030 Scenario: addr_ready_i=0 for 10 cycles with sel_width=3 -> exactly 4 pushes, then stall with no data loss; releasing it drains in order.
REQ-031 Scenario: clr_i asserted in the same cycle as start_i, and clr_i asserted mid-RUN -> IDLE, FIFO empty, no done_o; a later start restarts from chunk 0.
REQ-032 Scenario: elem=0 start -> no push, busy_o for one cycle, done_o pulses once.
